random_sequence_gen: RTL and testbench

Seeded pseudo-random symbol generator that sits directly downstream of the seed-capture stage. It loads the N-bit seed when that stage freezes its counter, then steps a Fibonacci LFSR once per request and emits a small symbol (e.g. button/LED index) with a one-cycle valid pulse. It can replay the identical sequence from the stored seed, which game logic uses to re-show a pattern. It stops after MAX_LEN symbols until it is restarted or reloaded.

---
 rtl/random_sequence_gen_if.sv | 36 +++
 rtl/random_sequence_gen.sv | 124 ++++++++++++
 tb/tb_random_sequence_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/random_sequence_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : random_sequence_gen_if
//  Purpose  : Bundles the control and symbol signals of random_sequence_gen.
//             The master side (game logic / seed-capture stage) drives seed,
//             load, restart and req. The slave side (the generator) returns
//             value, valid, index, seeded and done.
//  Ports    : none. clk and reset are plain ports on the modules.
//  Revision : 1.0  initial release
// ============================================================================
interface random_sequence_gen_if #(
    parameter int N     = 6,
    parameter int OUT_W = 2,
    parameter int IDX_W = 6
);
    logic [N-1:0]     seed;
    logic             load;
    logic             restart;
    logic             req;
    logic [OUT_W-1:0] value;
    logic             valid;
    logic [IDX_W-1:0] index;
    logic             seeded;
    logic             done;

    modport master (
        output seed, load, restart, req,
        input  value, valid, index, seeded, done
    );

    modport slave (
        input  seed, load, restart, req,
        output value, valid, index, seeded, done
    );
endinterface
`default_nettype wire

// File: rtl/random_sequence_gen.sv
`default_nettype none
// ============================================================================
//  Module   : random_sequence_gen
//  Purpose  : Seeded pseudo-random symbol generator. It captures a seed on
//             load, steps a Fibonacci LFSR once per accepted req and emits
//             the low OUT_W bits of the new state with a one-cycle valid
//             pulse. restart replays the sequence from the stored seed.
//             Generation stops after MAX_LEN symbols until a load or a
//             restart.
//  Ports    : clk     - clock, all logic on posedge
//             reset   - synchronous, active-high
//             bus     - slave modport: seed/load/restart/req in,
//                       value/valid/index/seeded/done out
//  Revision : 1.0  initial release
// ============================================================================
module random_sequence_gen #(
    parameter int           N       = 6,
    parameter logic [N-1:0] TAPS    = 6'b110000,
    parameter int           OUT_W   = 2,
    parameter int           MAX_LEN = 32,
    parameter int           IDX_W   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    random_sequence_gen_if.slave  bus
);

    localparam logic [IDX_W-1:0] c_MAX_LEN = IDX_W'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [N-1:0]     r_base;
    logic [N-1:0]     r_lfsr;
    logic [IDX_W-1:0] r_index;
    logic [OUT_W-1:0] r_value;
    logic             r_valid;
    logic             r_seeded;

    logic             w_restart_ok;
    logic             w_step;
    logic             w_fb;
    logic [N-1:0]     w_lfsr_next;
    logic [N-1:0]     w_seed_safe;
    logic [IDX_W-1:0] w_index_inc;

    // load wins over restart, restart wins over req; a lower-priority
    // request arriving alongside a higher one is simply dropped.
    assign w_restart_ok = bus.restart && !bus.load && (r_state != ST_UNSEEDED);
    assign w_step       = bus.req && !bus.load && !bus.restart && (r_state == ST_ACTIVE);

    assign w_fb        = ^(r_lfsr & TAPS);
    assign w_lfsr_next = {r_lfsr[N-2:0], w_fb};
    assign w_index_inc = r_index + 1'b1;

    // An all-zero LFSR never leaves zero, so a zero seed becomes all-ones.
    assign w_seed_safe = (bus.seed == '0) ? '1 : bus.seed;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_UNSEEDED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.load) begin
            w_state_next = ST_ACTIVE;
        end else if (w_restart_ok) begin
            w_state_next = ST_ACTIVE;
        end else if (w_step && (w_index_inc == c_MAX_LEN)) begin
            w_state_next = ST_DONE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= '0;
            r_lfsr   <= '0;
            r_index  <= '0;
            r_value  <= '0;
            r_valid  <= 1'b0;
            r_seeded <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.load) begin
                r_base   <= w_seed_safe;
                r_lfsr   <= w_seed_safe;
                r_index  <= '0;
                r_seeded <= 1'b1;
            end else if (w_restart_ok) begin
                r_lfsr  <= r_base;
                r_index <= '0;
            end else if (w_step) begin
                r_lfsr  <= w_lfsr_next;
                r_value <= w_lfsr_next[OUT_W-1:0];
                r_valid <= 1'b1;
                r_index <= w_index_inc;
            end
        end
    end

    assign bus.value  = r_value;
    assign bus.valid  = r_valid;
    assign bus.index  = r_index;
    assign bus.seeded = r_seeded;
    assign bus.done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_random_sequence_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_sequence_gen
//  Purpose  : Self-checking bench for random_sequence_gen. u_dut0 uses the
//             default MAX_LEN of 32, u_dut1 uses MAX_LEN = 4 to reach DONE
//             quickly. A small behavioural model of u_dut0 predicts its
//             outputs under random load/restart/req/seed traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_random_sequence_gen;

    localparam logic [5:0] c_TAPS = 6'b110000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    random_sequence_gen_if #(.N(6), .OUT_W(2), .IDX_W(6)) bus0 ();
    random_sequence_gen_if #(.N(6), .OUT_W(2), .IDX_W(6)) bus1 ();

    random_sequence_gen #(.N(6), .TAPS(c_TAPS), .OUT_W(2), .MAX_LEN(32), .IDX_W(6)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    random_sequence_gen #(.N(6), .TAPS(c_TAPS), .OUT_W(2), .MAX_LEN(4), .IDX_W(6)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model of u_dut0 (MAX_LEN = 32)
    // ------------------------------------------------------------------
    int m_base;
    int m_lfsr;
    int m_index;
    int m_value;
    int m_valid;
    int m_seeded;
    int m_mode;   // 0 = no seed yet, 1 = generating, 2 = finished

    // Next LFSR state: shift left by one, feed in the parity of tapped bits.
    function automatic int next_lfsr(input int s);
        int ones;
        ones = 0;
        for (int i = 0; i < 6; i++) begin
            if (((s >> i) & 1) == 1 && c_TAPS[i]) ones++;
        end
        return ((s * 2) + (ones % 2)) % 64;
    endfunction

    task automatic model_reset();
        m_base = 0; m_lfsr = 0; m_index = 0; m_value = 0;
        m_valid = 0; m_seeded = 0; m_mode = 0;
    endtask

    task automatic model_edge(input int ld, input int rs, input int rq, input int sd);
        m_valid = 0;
        if (ld != 0) begin
            m_base   = (sd == 0) ? 63 : sd;
            m_lfsr   = m_base;
            m_index  = 0;
            m_seeded = 1;
            m_mode   = 1;
        end else if (rs != 0 && m_mode != 0) begin
            m_lfsr  = m_base;
            m_index = 0;
            m_mode  = 1;
        end else if (rq != 0 && m_mode == 1) begin
            m_lfsr  = next_lfsr(m_lfsr);
            m_value = m_lfsr % 4;
            m_valid = 1;
            m_index = m_index + 1;
            if (m_index == 32) m_mode = 2;
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.seed = '0; bus0.load = 1'b0; bus0.restart = 1'b0; bus0.req = 1'b0;
        bus1.seed = '0; bus1.load = 1'b0; bus1.restart = 1'b0; bus1.req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        do_reset();
        bus0.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus0.valid !== 1'b0 || bus0.seeded !== 1'b0 || bus0.index !== 6'd0 ||
                bus0.value !== 2'd0 || bus0.done !== 1'b0) begin
                bad++;
                $display("FAIL reset_req%0d: valid=%b seeded=%b index=%0d value=%0d done=%b, expected all 0",
                         i, bus0.valid, bus0.seeded, bus0.index, bus0.value, bus0.done);
            end
        end
        bus0.req = 1'b0;
    endtask

    task automatic test_sequence();
        int exp_vals[6] = '{2, 0, 0, 0, 1, 3};
        bus0.seed = 6'b000001;
        bus0.load = 1'b1;
        tick();
        bus0.load = 1'b0;
        total++;
        if (bus0.seeded !== 1'b1 || bus0.index !== 6'd0 || bus0.valid !== 1'b0) begin
            bad++;
            $display("FAIL seq_load: seeded=%b index=%0d valid=%b, expected 1 0 0",
                     bus0.seeded, bus0.index, bus0.valid);
        end
        bus0.req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus0.valid !== 1'b1 || bus0.value !== 2'(exp_vals[i]) || bus0.index !== 6'(i + 1)) begin
                bad++;
                $display("FAIL seq_sym%0d: valid=%b value=%0d index=%0d, expected 1 %0d %0d",
                         i, bus0.valid, bus0.value, bus0.index, exp_vals[i], i + 1);
            end
        end
        bus0.req = 1'b0;
        tick();
        total++;
        if (bus0.valid !== 1'b0) begin
            bad++;
            $display("FAIL seq_idle_valid: valid=%b, expected 0", bus0.valid);
        end
    endtask

    task automatic test_zero_seed();
        bus0.seed = 6'b000000;
        bus0.load = 1'b1;
        tick();
        bus0.load = 1'b0;
        bus0.req  = 1'b1;
        tick();
        total++;
        if (bus0.valid !== 1'b1 || bus0.value !== 2'b10) begin
            bad++;
            $display("FAIL zero_seed_sym0: valid=%b value=%0d, expected 1 2", bus0.valid, bus0.value);
        end
        // 111110 -> 111100: low bits 0
        tick();
        total++;
        if (bus0.value !== 2'b00 || bus0.index !== 6'd2) begin
            bad++;
            $display("FAIL zero_seed_sym1: value=%0d index=%0d, expected 0 2", bus0.value, bus0.index);
        end
        bus0.req = 1'b0;
    endtask

    task automatic test_max_len();
        int pulses;
        pulses = 0;
        bus1.seed = 6'(1 + $urandom_range(0, 62));
        bus1.load = 1'b1;
        tick();
        bus1.load = 1'b0;
        bus1.req  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus1.valid === 1'b1) pulses++;
            total++;
            if (bus1.done !== ((i >= 3) ? 1'b1 : 1'b0) || bus1.valid !== ((i < 4) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL maxlen_cyc%0d: done=%b valid=%b, expected %0d %0d",
                         i, bus1.done, bus1.valid, (i >= 3), (i < 4));
            end
        end
        bus1.req = 1'b0;
        total++;
        if (pulses != 4 || bus1.index !== 6'd4) begin
            bad++;
            $display("FAIL maxlen_count: pulses=%0d index=%0d, expected 4 4", pulses, bus1.index);
        end
        bus1.restart = 1'b1;
        tick();
        bus1.restart = 1'b0;
        total++;
        if (bus1.done !== 1'b0 || bus1.index !== 6'd0 || bus1.valid !== 1'b0) begin
            bad++;
            $display("FAIL maxlen_restart: done=%b index=%0d valid=%b, expected 0 0 0",
                     bus1.done, bus1.index, bus1.valid);
        end
    endtask

    task automatic test_restart_replay();
        int exp_vals[5] = '{2, 0, 0, 0, 1};
        bus0.seed = 6'b000001;
        bus0.load = 1'b1;
        tick();
        bus0.load = 1'b0;
        bus0.req  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus0.req     = 1'b0;
        bus0.seed    = 6'b101010;   // must not matter without load
        bus0.restart = 1'b1;
        tick();
        bus0.restart = 1'b0;
        bus0.req     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus0.valid !== 1'b1 || bus0.value !== 2'(exp_vals[i]) || bus0.index !== 6'(i + 1)) begin
                bad++;
                $display("FAIL replay_sym%0d: valid=%b value=%0d index=%0d, expected 1 %0d %0d",
                         i, bus0.valid, bus0.value, bus0.index, exp_vals[i], i + 1);
            end
        end
        bus0.req = 1'b0;
    endtask

    task automatic test_load_with_req();
        bus0.req = 1'b1;
        tick();
        bus0.seed = 6'b000111;
        bus0.load = 1'b1;
        tick();
        bus0.load = 1'b0;
        bus0.req  = 1'b0;
        total++;
        if (bus0.valid !== 1'b0 || bus0.index !== 6'd0) begin
            bad++;
            $display("FAIL load_req_same: valid=%b index=%0d, expected 0 0", bus0.valid, bus0.index);
        end
    endtask

    task automatic test_restart_in_done();
        bus1.seed = 6'b000001;
        bus1.load = 1'b1;
        tick();
        bus1.load = 1'b0;
        bus1.req  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (bus1.done !== 1'b1) begin
            bad++;
            $display("FAIL rdone_reach: done=%b, expected 1", bus1.done);
        end
        bus1.restart = 1'b1;
        tick();
        bus1.restart = 1'b0;
        total++;
        if (bus1.done !== 1'b0 || bus1.valid !== 1'b0 || bus1.index !== 6'd0) begin
            bad++;
            $display("FAIL rdone_restart_req: done=%b valid=%b index=%0d, expected 0 0 0",
                     bus1.done, bus1.valid, bus1.index);
        end
        tick();
        bus1.req = 1'b0;
        total++;
        if (bus1.valid !== 1'b1 || bus1.value !== 2'd2 || bus1.index !== 6'd1) begin
            bad++;
            $display("FAIL rdone_next_req: valid=%b value=%0d index=%0d, expected 1 2 1",
                     bus1.valid, bus1.value, bus1.index);
        end
    endtask

    task automatic test_reset_burst();
        bus0.seed = 6'b011011;
        bus0.load = 1'b1;
        tick();
        bus0.load = 1'b0;
        bus0.req  = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (bus0.valid !== 1'b0 || bus0.value !== 2'd0 || bus0.index !== 6'd0 ||
            bus0.seeded !== 1'b0 || bus0.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_burst: valid=%b value=%0d index=%0d seeded=%b done=%b, expected all 0",
                     bus0.valid, bus0.value, bus0.index, bus0.seeded, bus0.done);
        end
        reset    = 1'b0;
        bus0.req = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int ld, rs, rq, sd;
        idle_inputs();
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            ld = ($urandom_range(0, 19) == 0) ? 1 : 0;
            rs = ($urandom_range(0, 14) == 0) ? 1 : 0;
            rq = ($urandom_range(0, 9) < 8) ? 1 : 0;
            sd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
            bus0.load    = ld[0];
            bus0.restart = rs[0];
            bus0.req     = rq[0];
            bus0.seed    = 6'(sd);
            tick();
            model_edge(ld, rs, rq, sd);
            total++;
            if (bus0.valid !== 1'(m_valid) || bus0.value !== 2'(m_value) ||
                bus0.index !== 6'(m_index) || bus0.seeded !== 1'(m_seeded) ||
                bus0.done !== ((m_mode == 2) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL random_c%0d: valid=%b value=%0d index=%0d seeded=%b done=%b, expected %0d %0d %0d %0d %0d",
                         c, bus0.valid, bus0.value, bus0.index, bus0.seeded, bus0.done,
                         m_valid, m_value, m_index, m_seeded, (m_mode == 2));
            end
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_sequence();
        test_zero_seed();
        test_max_len();
        test_restart_replay();
        test_load_with_req();
        test_restart_in_done();
        test_reset_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
